uart_loopback_checker: RTL
==========================

# uart_loopback_checker

Self-checking traffic source and sink for the far end of a UART loopback link. On a start pulse it drives a fixed number of pseudo-random bytes into the async transmitter handshake, one byte in flight at a time. It compares each byte returned by the async receiver against the byte sent, and reports error and timeout counts plus a pass flag. Used to qualify baud rates and cabling on the iCE40HX-8K board.

## Interface
Parameters:
- `NUM_BYTES`, 256: bytes per run; range 1..65535.
- `TIMEOUT_CYCLES`, 4096: clocks to wait for an echo before declaring timeout; must be ≥ 2.
- `SEED`, 8'h01: LFSR start value; must be nonzero.

Ports:
- `clk`  in  1: system clock, all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse; begins a run from IDLE or DONE, ignored otherwise.
- `tx_busy`  in  1: transmitter busy, from async_transmitter TxD_busy.
- `tx_start`  out  1: one-cycle transmit request, to TxD_start.
- `tx_data`  out  8: byte to send, to TxD_data; held stable until the next request.
- `rx_data_ready`  in  1: one-cycle received-byte strobe, from RxD_data_ready.
- `rx_data`  in  8: received byte, valid with rx_data_ready.
- `busy`  out  1: high while a run is active (SEND or WAIT_ECHO).
- `done`  out  1: high from run completion until the next start or reset.
- `pass`  out  1: done and err_count == 0.
- `err_count`  out  16: mismatches + timeouts + stray bytes; saturates at 16'hFFFF.
- `timeout_count`  out  16: timeouts only; saturates at 16'hFFFF.
- `last_bad`  out  8: most recent mismatching received byte (for LEDs).

## Operation
- States: IDLE, SEND, WAIT_ECHO, DONE.
- Pattern: 8-bit Fibonacci LFSR, next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, loaded with SEED at start. With SEED=01 the sequence is 01,02,04,08,11,23,…
- IDLE/DONE, start=1: clear all counters, last_bad, done, and the byte counter; load LFSR = SEED; go to SEND.
- SEND, tx_busy=0: register tx_start=1 and tx_data=lfsr; clear the timer; go to WAIT_ECHO. While tx_busy=1, remain in SEND.
- WAIT_ECHO, rx_data_ready=1:
  - If rx_data != tx_data, increment err_count and set last_bad = rx_data.
  - Then advance the byte.
- WAIT_ECHO, timer == TIMEOUT_CYCLES-1 with no rx_data_ready: increment err_count and timeout_count, then advance the byte.
- Advance byte: step the LFSR and increment the byte counter. If the counter reaches NUM_BYTES, go to DONE; otherwise go to SEND.
- rx_data_ready in IDLE, SEND or DONE is a stray byte: increment err_count, set last_bad = rx_data, no state change. This includes a late echo after a timeout.
- start while busy: ignored.
- Counter increments saturate. The byte counter is 16 bits.

## Timing
- Reset values: tx_start=0, tx_data=00, busy=0, done=0, pass=0, err_count=0, timeout_count=0, last_bad=00, state IDLE, LFSR=SEED.
- Reset mid-run drops the run immediately; no tx_start is issued after reset asserts.
- All outputs are registered.
- start sampled at edge N → state SEND and busy=1 after edge N.
- tx_start is high for exactly one cycle, in the cycle after SEND sees tx_busy=0. It is never asserted while tx_busy was high at the deciding edge.
- The timer counts from the cycle tx_start is high. A timeout fires on the TIMEOUT_CYCLES-th clock with no echo.
- rx_data_ready and timeout at the same edge: the echo wins, is compared, and no timeout is counted.
- Final byte: done=1 and busy=0 one cycle after the deciding echo or timeout edge. pass is valid in the same cycle as done.
- Max throughput is one byte per (transmit time + receive latency + 2 clocks).

## Test plan
- Ideal loopback (rx echoes tx_data 3 cycles after tx_start ends, tx_busy high for 10 cycles), NUM_BYTES=5, SEED=01 → tx_data sequence 01,02,04,08,11; done=1, pass=1, err_count=0.
- Corrupt the 3rd echo to FB → err_count=1, last_bad=FB, timeout_count=0, pass=0; remaining bytes still checked.
- Suppress the 2nd echo, TIMEOUT_CYCLES=16 → timeout 16 clocks after its tx_start, err_count=1, timeout_count=1, run completes. A late echo injected afterwards in SEND raises err_count to 2.
- Hold tx_busy=1 for 50 cycles during SEND → no tx_start until the cycle after tx_busy falls. start pulsed mid-run → ignored, byte count unaffected.
- Assert reset during WAIT_ECHO of byte 3 → all outputs return to reset values and stay so. A new start then replays from 01.
- Force every echo wrong with NUM_BYTES=65535 (or preload the counter near FFFF) → err_count saturates at FFFF without wrap.

Source files
------------

// File: rtl/uart_loopback_checker.sv
// Far-end UART loopback qualifier: sends a run of LFSR bytes one at a time,
// checks every echo, and counts mismatches, timeouts and stray bytes.
module uart_loopback_checker #(
    parameter int         NUM_BYTES      = 256,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] SEED           = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        rx_data_ready,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] timeout_count,
    output logic [7:0]  last_bad,
    output logic [1:0]  dbg_state
);

    // Handshakes: tx_start is a one-cycle request issued only after tx_busy
    // was low at the deciding edge; rx_data is only looked at when
    // rx_data_ready is high, and every such strobe is consumed in that cycle.

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_ECHO = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam int              TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]     BYTES_LAST = 16'(NUM_BYTES - 1);

    state_t        r_state;
    logic [7:0]    r_lfsr;
    logic [15:0]   r_byte_cnt;
    logic [TW-1:0] r_timer;
    logic          r_tx_start;
    logic [7:0]    r_tx_data;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [15:0]   r_err;
    logic [15:0]   r_to;
    logic [7:0]    r_last_bad;

    logic [7:0]    w_lfsr_next;
    logic          w_start_ok;
    logic          w_echo;
    logic          w_timeout;
    logic          w_mismatch;
    logic          w_stray;
    logic          w_err_bump;
    logic [15:0]   w_err_next;
    logic          w_last;

    always_comb begin
        w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
        w_echo      = (r_state == S_WAIT_ECHO) && rx_data_ready;
        // An echo arriving on the timeout edge wins over the timeout.
        w_timeout   = (r_state == S_WAIT_ECHO) && !rx_data_ready && (r_timer == TIMER_LAST);
        w_mismatch  = w_echo && (rx_data != r_tx_data);
        w_stray     = rx_data_ready && (r_state != S_WAIT_ECHO);
        w_err_bump  = w_mismatch || w_timeout || w_stray;
        w_err_next  = (w_err_bump && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;
        w_last      = (r_byte_cnt == BYTES_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED;
            r_byte_cnt <= 16'd0;
            r_timer    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= 16'd0;
            r_to       <= 16'd0;
            r_last_bad <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            if (w_start_ok) begin
                r_state    <= S_SEND;
                r_lfsr     <= SEED;
                r_byte_cnt <= 16'd0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
                r_err      <= 16'd0;
                r_to       <= 16'd0;
                r_last_bad <= 8'h00;
            end else begin
                r_err <= w_err_next;
                if (w_stray || w_mismatch) r_last_bad <= rx_data;
                if (w_timeout && r_to != 16'hFFFF) r_to <= r_to + 16'd1;
                case (r_state)
                    S_SEND: begin
                        if (!tx_busy) begin
                            r_tx_start <= 1'b1;
                            r_tx_data  <= r_lfsr;
                            r_timer    <= '0;
                            r_state    <= S_WAIT_ECHO;
                        end
                    end
                    S_WAIT_ECHO: begin
                        if (w_echo || w_timeout) begin
                            r_lfsr <= w_lfsr_next;
                            if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_pass  <= (w_err_next == 16'd0);
                            end else begin
                                r_state <= S_SEND;
                            end
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    // Stray bytes after completion must also drop pass.
                    S_DONE:  r_pass <= (w_err_next == 16'd0);
                    default: ;
                endcase
            end
        end
    end

    assign tx_start      = r_tx_start;
    assign tx_data       = r_tx_data;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err;
    assign timeout_count = r_to;
    assign last_bad      = r_last_bad;
    assign dbg_state     = r_state;

endmodule
